// File: rtl/jzjpcc_memory_arbiter_pkg.sv
// jzjpcc_memory_pkg
// Shared types for the fetch/data memory arbiter.
//   rsp_owner_t  : which requester owns the read data coming back next cycle
//   WORD_ADDR_W  : width of a word address [31:2]
//   mem_req_t    : one access as presented to the shared memory port
package jzjpcc_memory_pkg;

   localparam int WORD_ADDR_W = 30;

   typedef enum logic [1:0] {
      RSP_NONE  = 2'd0,
      RSP_FETCH = 2'd1,
      RSP_DATA  = 2'd2
   } rsp_owner_t;

   typedef struct packed {
      logic [WORD_ADDR_W-1:0] address;
      logic [31:0]            writeData;
      logic [3:0]             byteMask;
      logic                   writeEnable;
   } mem_req_t;

endpackage

// File: rtl/jzjpcc_memory_arbiter_if.sv
// jzjpcc_memory_arbiter_if
// Bundles the fetch port, the data port and the shared memory port.
//   slave  : seen by the arbiter (takes requests and memory read data,
//            drives grants, stalls, responses and the memory request)
//   master : seen by the pipeline and memory side
interface jzjpcc_memory_arbiter_if;
   import jzjpcc_memory_pkg::*;

   logic                   fetchReq;
   logic [WORD_ADDR_W-1:0] fetchAddress;
   logic                   fetchGnt;
   logic                   fetchStall;
   logic                   fetchRdValid;
   logic [31:0]            fetchRdData;

   logic                   dataReq;
   logic                   dataWrite;
   logic [WORD_ADDR_W-1:0] dataAddress;
   logic [31:0]            dataWriteData;
   logic [3:0]             dataByteMask;
   logic                   dataGnt;
   logic                   dataStall;
   logic                   dataRdValid;
   logic [31:0]            dataRdData;

   logic [WORD_ADDR_W-1:0] memAddress;
   logic [31:0]            memDataToWrite;
   logic [3:0]             memByteMask;
   logic                   memWriteEnable;
   logic [31:0]            memDataRead;

   modport slave (
      input  fetchReq, fetchAddress,
      output fetchGnt, fetchStall, fetchRdValid, fetchRdData,
      input  dataReq, dataWrite, dataAddress, dataWriteData, dataByteMask,
      output dataGnt, dataStall, dataRdValid, dataRdData,
      output memAddress, memDataToWrite, memByteMask, memWriteEnable,
      input  memDataRead
   );

   modport master (
      output fetchReq, fetchAddress,
      input  fetchGnt, fetchStall, fetchRdValid, fetchRdData,
      output dataReq, dataWrite, dataAddress, dataWriteData, dataByteMask,
      input  dataGnt, dataStall, dataRdValid, dataRdData,
      input  memAddress, memDataToWrite, memByteMask, memWriteEnable,
      output memDataRead
   );

endinterface

// File: rtl/jzjpcc_memory_arbiter_starve.sv
// jzjpcc_memory_arbiter_starve
// Counts consecutive cycles in which fetch asked and was refused. Once the
// count reaches STARVE_LIMIT and both requesters are asking, force_fetch
// hands the port to fetch for one cycle.
//   clock, reset : system clock, asynchronous active-high reset
//   fetch_req    : fetch is requesting this cycle
//   data_req     : data is requesting this cycle
//   fetch_gnt    : fetch actually won this cycle
//   force_fetch  : override data priority this cycle
module jzjpcc_memory_arbiter_starve #(
   parameter int STARVE_LIMIT = 4
) (
   input  logic clock,
   input  logic reset,
   input  logic fetch_req,
   input  logic data_req,
   input  logic fetch_gnt,
   output logic force_fetch
);

   localparam int CW = $clog2(STARVE_LIMIT + 1);
   localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

   logic [CW-1:0] starve_count;

   // Saturating denial counter; any grant or a dropped request starts over.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         starve_count <= '0;
      end else if (!fetch_req || fetch_gnt) begin
         starve_count <= '0;
      end else if (starve_count != LIMIT) begin
         starve_count <= starve_count + 1'b1;
      end
   end

   // Only override when there is actually a conflict to resolve.
   assign force_fetch = (starve_count == LIMIT) && fetch_req && data_req;

endmodule

// File: rtl/jzjpcc_memory_arbiter.sv
// jzjpcc_memory_arbiter
// Shares one synchronous single-port memory between the fetch stage and the
// memory stage. Data has priority; the loser gets a stall. Read data comes
// back one cycle after the grant and is tagged to the winner by a small
// response FSM.
//   clock, reset : system clock, asynchronous active-high reset
//   bus          : jzjpcc_memory_arbiter_if.slave (fetch, data, memory ports)
// Optional build macro JZJPCC_ARB_STARVE_GUARD_EN adds a starvation guard
// that lets fetch win once after STARVE_LIMIT consecutive denials.
module jzjpcc_memory_arbiter
   import jzjpcc_memory_pkg::*;
#(
   parameter int STARVE_LIMIT = 4,
   parameter int ADDR_MSB     = 31
) (
   input logic                     clock,
   input logic                     reset,
   jzjpcc_memory_arbiter_if.slave  bus
);

   if (STARVE_LIMIT < 1) begin : g_bad_limit
      $error("STARVE_LIMIT must be at least 1");
   end

   logic                  fetch_gnt;
   logic                  data_gnt;
   logic                  force_fetch;
   logic [ADDR_MSB-2:0]   address_hold;
   mem_req_t              mem_req;
   rsp_owner_t            state;
   rsp_owner_t            state_next;

`ifdef JZJPCC_ARB_STARVE_GUARD_EN
   jzjpcc_memory_arbiter_starve #(
      .STARVE_LIMIT (STARVE_LIMIT)
   ) u_starve (
      .clock       (clock),
      .reset       (reset),
      .fetch_req   (bus.fetchReq),
      .data_req    (bus.dataReq),
      .fetch_gnt   (fetch_gnt),
      .force_fetch (force_fetch)
   );
`else
   assign force_fetch = 1'b0;
`endif

   // Data wins unless the starvation guard is forcing fetch through.
   assign data_gnt  = bus.dataReq && !force_fetch;
   assign fetch_gnt = bus.fetchReq && (!bus.dataReq || force_fetch);

   assign bus.dataGnt    = data_gnt;
   assign bus.fetchGnt   = fetch_gnt;
   assign bus.dataStall  = bus.dataReq && !data_gnt;
   assign bus.fetchStall = bus.fetchReq && !fetch_gnt;

   // Memory port mux. Idle cycles keep the last address on the bus so the
   // memory sees a quiet address line; the write strobe is held off in reset.
   always_comb begin
      mem_req = '{address: address_hold, writeData: '0, byteMask: '0, writeEnable: 1'b0};
      if (data_gnt) begin
         mem_req = '{address:     bus.dataAddress,
                     writeData:   bus.dataWriteData,
                     byteMask:    bus.dataByteMask,
                     writeEnable: bus.dataWrite};
      end else if (fetch_gnt) begin
         mem_req.address = bus.fetchAddress;
      end
      if (reset) begin
         mem_req.writeEnable = 1'b0;
      end
   end

   assign bus.memAddress     = mem_req.address;
   assign bus.memDataToWrite = mem_req.writeData;
   assign bus.memByteMask    = mem_req.byteMask;
   assign bus.memWriteEnable = mem_req.writeEnable;

   // Remember the last granted address for idle cycles.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         address_hold <= '0;
      end else if (data_gnt || fetch_gnt) begin
         address_hold <= mem_req.address;
      end
   end

   // Response owner register; reset discards any outstanding read.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= RSP_NONE;
      end else begin
         state <= state_next;
      end
   end

   // Stores never come back, so only fetches and loads claim the next cycle.
   always_comb begin
      state_next = RSP_NONE;
      if (fetch_gnt) begin
         state_next = RSP_FETCH;
      end else if (data_gnt && !bus.dataWrite) begin
         state_next = RSP_DATA;
      end
   end

   // Both consumers see the raw memory data and qualify it with their valid.
   always_comb begin
      bus.fetchRdValid = (state == RSP_FETCH);
      bus.dataRdValid  = (state == RSP_DATA);
      bus.fetchRdData  = bus.memDataRead;
      bus.dataRdData   = bus.memDataRead;
   end

endmodule

// File: tb/tb_jzjpcc_memory_arbiter.sv
// tb_jzjpcc_memory_arbiter
// Directed bench for jzjpcc_memory_arbiter with a write-first synchronous
// memory model hanging off the shared port. Honours
// JZJPCC_ARB_STARVE_GUARD_EN for the starvation section.
module tb_jzjpcc_memory_arbiter;
   import jzjpcc_memory_pkg::*;

   logic clock;
   logic reset;
   int   checks;
   int   errors;

   logic [31:0] memArray [0:1023];

   jzjpcc_memory_arbiter_if bus ();

   jzjpcc_memory_arbiter #(
      .STARVE_LIMIT (4),
      .ADDR_MSB     (31)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Write-first single-port memory: a read of the word being written
   // returns the merged new value on the next cycle.
   always @(posedge clock) begin
      mem_req_t   req;
      logic [31:0] word;
      req  = '{address: bus.memAddress, writeData: bus.memDataToWrite,
               byteMask: bus.memByteMask, writeEnable: bus.memWriteEnable};
      word = memArray[req.address[9:0]];
      if (req.writeEnable) begin
         for (int b = 0; b < 4; b++) begin
            if (req.byteMask[b]) word[8*b +: 8] = req.writeData[8*b +: 8];
         end
         memArray[req.address[9:0]] <= word;
      end
      bus.memDataRead <= word;
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s observed 0x%08h expected 0x%08h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic fReq, input logic [29:0] fAddr,
                                input logic dReq, input logic dWrite,
                                input logic [29:0] dAddr, input logic [31:0] dData,
                                input logic [3:0] dMask);
      bus.fetchReq      = fReq;
      bus.fetchAddress  = fAddr;
      bus.dataReq       = dReq;
      bus.dataWrite     = dWrite;
      bus.dataAddress   = dAddr;
      bus.dataWriteData = dData;
      bus.dataByteMask  = dMask;
   endtask

   task automatic stepCycle();
      @(posedge clock);
      #1;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      for (int i = 0; i < 1024; i++) memArray[i] = 32'h0;
      memArray[30'h40] = 32'h0000_00A0;
      memArray[30'h41] = 32'h0000_00A1;
      memArray[30'h42] = 32'h0000_00A2;
      memArray[30'h80] = 32'hDEAD_BEEF;
      memArray[30'h10] = 32'h0000_0000;
      bus.memDataRead = 32'h0;
      reset = 1'b1;
      applyStimulus(1'b0, 30'h0, 1'b0, 1'b0, 30'h0, 32'h0, 4'h0);

      // Reset state
      stepCycle();
      stepCycle();
      checkOutput("rst_fetchRdValid", {31'b0, bus.fetchRdValid}, 32'h0);
      checkOutput("rst_dataRdValid", {31'b0, bus.dataRdValid}, 32'h0);
      checkOutput("rst_memAddress", {2'b0, bus.memAddress}, 32'h0);
      checkOutput("rst_memWriteEnable", {31'b0, bus.memWriteEnable}, 32'h0);
      reset = 1'b0;
      stepCycle();

      // Fetch-only stream at byte 0x100, 0x104, 0x108
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 30'h40 + 30'(i), 1'b0, 1'b0, 30'h0, 32'h0, 4'h0);
         #1;
         checkOutput($sformatf("fetch_gnt_%0d", i), {31'b0, bus.fetchGnt}, 32'h1);
         checkOutput($sformatf("fetch_stall_%0d", i), {31'b0, bus.fetchStall}, 32'h0);
         checkOutput($sformatf("fetch_addr_%0d", i), {2'b0, bus.memAddress}, 32'h40 + i);
         if (i > 0) begin
            checkOutput($sformatf("fetch_valid_%0d", i), {31'b0, bus.fetchRdValid}, 32'h1);
            checkOutput($sformatf("fetch_data_%0d", i), bus.fetchRdData, 32'hA0 + i - 1);
         end
         stepCycle();
      end
      applyStimulus(1'b0, 30'h0, 1'b0, 1'b0, 30'h0, 32'h0, 4'h0);
      #1;
      checkOutput("fetch_valid_last", {31'b0, bus.fetchRdValid}, 32'h1);
      checkOutput("fetch_data_last", bus.fetchRdData, 32'hA2);
      checkOutput("idle_addr_hold", {2'b0, bus.memAddress}, 32'h42);
      checkOutput("idle_mask", {28'b0, bus.memByteMask}, 32'h0);
      checkOutput("idle_we", {31'b0, bus.memWriteEnable}, 32'h0);
      stepCycle();
      checkOutput("idle_fetch_valid", {31'b0, bus.fetchRdValid}, 32'h0);

      // Conflict: data load at byte 0x200 against a fetch
      applyStimulus(1'b1, 30'h40, 1'b1, 1'b0, 30'h80, 32'h0, 4'h0);
      #1;
      checkOutput("conf_dataGnt", {31'b0, bus.dataGnt}, 32'h1);
      checkOutput("conf_fetchGnt", {31'b0, bus.fetchGnt}, 32'h0);
      checkOutput("conf_fetchStall", {31'b0, bus.fetchStall}, 32'h1);
      checkOutput("conf_memAddress", {2'b0, bus.memAddress}, 32'h80);
      stepCycle();
      applyStimulus(1'b0, 30'h0, 1'b0, 1'b0, 30'h0, 32'h0, 4'h0);
      #1;
      checkOutput("conf_dataRdValid", {31'b0, bus.dataRdValid}, 32'h1);
      checkOutput("conf_dataRdData", bus.dataRdData, 32'hDEAD_BEEF);
      checkOutput("conf_fetchRdValid", {31'b0, bus.fetchRdValid}, 32'h0);
      stepCycle();

      // Store low half at byte 0x40, then load it back
      applyStimulus(1'b0, 30'h0, 1'b1, 1'b1, 30'h10, 32'h1234_5678, 4'b0011);
      #1;
      checkOutput("st_we", {31'b0, bus.memWriteEnable}, 32'h1);
      checkOutput("st_mask", {28'b0, bus.memByteMask}, 32'h3);
      checkOutput("st_wdata", bus.memDataToWrite, 32'h1234_5678);
      stepCycle();
      applyStimulus(1'b0, 30'h0, 1'b1, 1'b0, 30'h10, 32'h0, 4'h0);
      #1;
      checkOutput("ld_we", {31'b0, bus.memWriteEnable}, 32'h0);
      checkOutput("ld_no_store_rsp", {31'b0, bus.dataRdValid}, 32'h0);
      stepCycle();
      applyStimulus(1'b0, 30'h0, 1'b0, 1'b0, 30'h0, 32'h0, 4'h0);
      #1;
      checkOutput("ld_valid", {31'b0, bus.dataRdValid}, 32'h1);
      checkOutput("ld_data", bus.dataRdData, 32'h0000_5678);
      stepCycle();

      // Fetch granted, reset lands before the response edge
      applyStimulus(1'b1, 30'h41, 1'b0, 1'b0, 30'h0, 32'h0, 4'h0);
      #1;
      checkOutput("rmid_fetchGnt", {31'b0, bus.fetchGnt}, 32'h1);
      #3;
      reset = 1'b1;
      applyStimulus(1'b1, 30'h41, 1'b1, 1'b1, 30'h10, 32'hFFFF_FFFF, 4'hF);
      #1;
      checkOutput("rmid_dataGnt_in_reset", {31'b0, bus.dataGnt}, 32'h1);
      checkOutput("rmid_fetchStall_in_reset", {31'b0, bus.fetchStall}, 32'h1);
      checkOutput("rmid_we_in_reset", {31'b0, bus.memWriteEnable}, 32'h0);
      stepCycle();
      checkOutput("rmid_valid_in_reset", {31'b0, bus.fetchRdValid}, 32'h0);
      applyStimulus(1'b0, 30'h0, 1'b0, 1'b0, 30'h0, 32'h0, 4'h0);
      reset = 1'b0;
      stepCycle();
      checkOutput("rmid_fetch_valid_after", {31'b0, bus.fetchRdValid}, 32'h0);
      checkOutput("rmid_data_valid_after", {31'b0, bus.dataRdValid}, 32'h0);
      applyStimulus(1'b0, 30'h0, 1'b1, 1'b0, 30'h10, 32'h0, 4'h0);
      stepCycle();
      applyStimulus(1'b0, 30'h0, 1'b0, 1'b0, 30'h0, 32'h0, 4'h0);
      #1;
      checkOutput("rmid_no_write", bus.dataRdData, 32'h0000_5678);
      stepCycle();

      // Both requesters held for 20 cycles
      for (int i = 0; i < 20; i++) begin
         applyStimulus(1'b1, 30'h40, 1'b1, 1'b0, 30'h80, 32'h0, 4'h0);
         #1;
`ifdef JZJPCC_ARB_STARVE_GUARD_EN
         checkOutput($sformatf("starve_fetchGnt_%0d", i), {31'b0, bus.fetchGnt},
                     ((i % 5) == 4) ? 32'h1 : 32'h0);
         checkOutput($sformatf("starve_dataStall_%0d", i), {31'b0, bus.dataStall},
                     ((i % 5) == 4) ? 32'h1 : 32'h0);
`else
         checkOutput($sformatf("prio_fetchGnt_%0d", i), {31'b0, bus.fetchGnt}, 32'h0);
         checkOutput($sformatf("prio_dataStall_%0d", i), {31'b0, bus.dataStall}, 32'h0);
`endif
         stepCycle();
      end
      applyStimulus(1'b0, 30'h0, 1'b0, 1'b0, 30'h0, 32'h0, 4'h0);
      stepCycle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/jzjpcc_memory_arbiter.md
Name: jzjpcc_memory_arbiter

Overview:
Shares one synchronous single-port memory between the fetch stage (read-only) and the memory stage (load/store). Each cycle it grants the port to one requester and drives the shared address, write-data, byte-mask and write-enable. It routes the read data, which returns one cycle later, back to the requester that was granted. It also produces the stall signals the pipeline control uses to freeze the stage that lost arbitration.

Parameters:
STARVE_LIMIT, 4, consecutive fetch denials before fetch is forced to win (used only with the optional feature).
ADDR_MSB, 31, MSB of the word address; the word address is [ADDR_MSB:2].

Ports:
clock  in  1  system clock
reset  in  1  reset, asynchronous, active-high
fetchReq  in  1  fetch requests a word read this cycle
fetchAddress  in  30  fetch word address [31:2]
fetchGnt  out  1  fetch granted this cycle (combinational)
fetchStall  out  1  fetchReq & ~fetchGnt
fetchRdValid  out  1  fetchRdData valid (one cycle after the grant)
fetchRdData  out  32  read data for fetch
dataReq  in  1  memory stage requests the port
dataWrite  in  1  1 = store, 0 = load
dataAddress  in  30  data word address
dataWriteData  in  32  store data
dataByteMask  in  4  store byte enables
dataGnt  out  1  data granted this cycle (combinational)
dataStall  out  1  dataReq & ~dataGnt
dataRdValid  out  1  dataRdData valid (loads only)
dataRdData  out  32  read data for data stage
memAddress  out  30  shared memory word address
memDataToWrite  out  32  shared memory write data
memByteMask  out  4  shared memory byte mask
memWriteEnable  out  1  shared memory write strobe
memDataRead  in  32  memory read data, valid the cycle after the address is presented

Behaviour:
- Grant logic is combinational from the requests and registered state; there is at most one grant per cycle.
- Default priority is data over fetch: dataGnt = dataReq; fetchGnt = fetchReq & ~dataReq.
- Mux: when data is granted, mem* take the data* fields and memWriteEnable = dataWrite.
- When fetch is granted, mem* take fetchAddress, memByteMask = 4'b0000, memWriteEnable = 0 and memDataToWrite = 0.
- When idle, memWriteEnable = 0, memByteMask = 0, and memAddress holds its last value (registered copy).
- Response FSM (registered) has states RSP_NONE, RSP_FETCH and RSP_DATA.
- Next state is RSP_FETCH if fetch is granted, RSP_DATA if data is granted with dataWrite = 0, otherwise RSP_NONE. A store never produces a response.
- fetchRdValid = (state == RSP_FETCH); dataRdValid = (state == RSP_DATA).
- fetchRdData and dataRdData both carry memDataRead. Consumers qualify with the valid signals.
- Back-to-back grants are fully pipelined: a new grant may issue in the same cycle a response returns. Throughput is 1 access per cycle.
- A write in cycle N followed by a read of the same address in cycle N+1 returns the new data. This is the memory's write-first property; the arbiter does not forward.
- Reset: state = RSP_NONE; all valid outputs are 0; registered memAddress = 0; starve counter = 0.
- Reset asserted mid-transaction drops any outstanding response: the valid signal is 0 on the first cycle after reset releases, even if a grant occurred the cycle before reset.
- Grant and stall outputs are combinational and therefore follow the requests during reset. memWriteEnable is forced to 0 while reset is high.
- Simultaneous requests with no optional feature: data wins and fetch stalls for as long as dataReq stays high.

Optional Feature:
JZJPCC_ARB_STARVE_GUARD_EN
- Enabled: a saturating counter increments each cycle fetchReq & ~fetchGnt, and clears on fetchGnt or when fetchReq is low.
  - When the counter == STARVE_LIMIT and both requesters ask, fetch wins for exactly one cycle and dataStall asserts.
  - The counter then clears.
  - Fetch therefore waits at most STARVE_LIMIT cycles.
- Disabled: the counter is absent and the pure data-priority rule applies.

Decomposition:
- Package jzjpcc_memory_pkg holds:
  - typedef enum rsp_owner_t {RSP_NONE, RSP_FETCH, RSP_DATA};
  - the localparam word-address width;
  - a packed struct mem_req_t {address, writeData, byteMask, writeEnable}, used by both the mux and the bench.
- One sub-module, jzjpcc_memory_arbiter_starve, holds the starve counter and force-fetch output. It is instantiated only under the macro.

Test Plan:
- Fetch-only: fetchReq = 1 at 0x100, 0x104, 0x108 on consecutive cycles -> fetchGnt = 1 every cycle; fetchRdValid = 1 one cycle later each time, carrying preloaded words 0xA0, 0xA1, 0xA2.
- Conflict: both request, data is a load at 0x200 (holds 0xDEADBEEF) -> dataGnt = 1, fetchStall = 1; next cycle dataRdValid = 1 with 0xDEADBEEF and fetchRdValid = 0.
- Store then load: cycle N store 0x12345678 mask 4'b0011 at 0x40 (was 0), cycle N+1 load 0x40 -> memWriteEnable = 1 only in cycle N; dataRdValid in N+2 with 0x00005678; no valid in N+1.
- Reset mid-read: fetch granted in cycle N, reset pulsed in cycle N+1 -> fetchRdValid = 0 throughout and after release; memWriteEnable = 0 during reset.
- With JZJPCC_ARB_STARVE_GUARD_EN and STARVE_LIMIT = 4: dataReq held high with fetchReq high -> fetch granted in the 5th cycle with dataStall = 1; pattern repeats every 5 cycles.
- Without the macro, same stimulus -> fetchGnt never asserts over 20 cycles.
